// File: rtl/mips_muldiv_pkg.sv
// Shared encodings, FSM states and helpers for the iterative multiply/divide unit.
package mips_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Wide enough for a 2*64-bit product; callers truncate to their own width.
  localparam int unsigned NEG_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  function automatic logic [NEG_W-1:0] neg(input logic [NEG_W-1:0] x);
    return ~x + NEG_W'(1);
  endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Controller <-> multiply/divide unit handshake and HI/LO result bus.
interface mips_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mips_muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next
);
  localparam int unsigned W = WIDTH;

  logic [W:0]   sum;
  logic [W:0]   rem_sh;
  logic [W-1:0] diff;

  // Multiply keeps the multiplier in the low half and shifts the product in from the top;
  // divide shifts the dividend out of the low half and quotient bits in at bit 0.
  always_comb begin
    sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    rem_sh   = acc[2*W-1:W-1];
    diff     = rem_sh[W-1:0] - opnd;
    acc_next = {sum, acc[W-1:1]};
    if (div_mode) begin
      if (rem_sh >= {1'b0, opnd}) acc_next = {diff, acc[W-2:0], 1'b1};
      else                        acc_next = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers and cancel.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mips_muldiv_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     acc, acc_step, prod;
  logic [WIDTH-1:0]  opnd;
  logic              div_mode, neg_res, neg_rem, dz_lat;
  logic              busy_q, done_q, dz_q;
  logic [WIDTH-1:0]  hi_q, lo_q;

  logic              load, step_en, wr_res, wr_hi, wr_lo;
  logic              is_div, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag, rem, quo, res_hi, res_lo;

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .div_mode (div_mode),
    .acc_next (acc_step)
  );

  // Operand magnitudes and signs presented at the start edge.
  always_comb begin
    is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg     = is_signed & bus.a[WIDTH-1];
    b_neg     = is_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? WIDTH'(neg(NEG_W'(bus.a))) : bus.a;
    b_mag     = b_neg ? WIDTH'(neg(NEG_W'(bus.b))) : bus.b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step_en = 1'b0;
    wr_res  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MULT || bus.op == OP_MULTU || is_div) begin
            load    = 1'b1;
            state_n = CALC;
          end else if (bus.op == OP_MTHI) begin
            wr_hi = 1'b1;
          end else if (bus.op == OP_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_n = IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt == CW'(1)) state_n = FIXUP;
        end
      end
      FIXUP: begin
        state_n = IDLE;
        wr_res  = ~bus.cancel;
      end
      default: state_n = IDLE;
    endcase
  end

  // Sign fixup; divide-by-zero forces an all-ones quotient and returns the dividend in HI.
  always_comb begin
    prod   = neg_res ? AW'(neg(NEG_W'(acc))) : acc;
    rem    = neg_rem ? WIDTH'(neg(NEG_W'(acc[AW-1:WIDTH]))) : acc[AW-1:WIDTH];
    quo    = neg_res ? WIDTH'(neg(NEG_W'(acc[WIDTH-1:0]))) : acc[WIDTH-1:0];
    res_hi = prod[AW-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (div_mode) begin
      res_hi = rem;
      res_lo = dz_lat ? {WIDTH{1'b1}} : quo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz_lat   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      busy_q <= (state_n != IDLE);
      done_q <= wr_res | wr_hi | wr_lo;
      dz_q   <= wr_res & div_mode & dz_lat;
      if (load) begin
        cnt      <= CW'(WIDTH);
        div_mode <= is_div;
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        dz_lat   <= (bus.b == '0);
        if (is_div) begin
          acc  <= {{WIDTH{1'b0}}, a_mag};
          opnd <= b_mag;
        end else begin
          acc  <= {{WIDTH{1'b0}}, b_mag};
          opnd <= a_mag;
        end
      end else if (step_en) begin
        cnt <= cnt - CW'(1);
        acc <= acc_step;
      end
      if (wr_res) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (wr_hi) hi_q <= bus.a;
      if (wr_lo) lo_q <= bus.a;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed-vector bench for mips_muldiv at WIDTH=32 and WIDTH=8.
module tb_mips_muldiv;
  import mips_muldiv_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mips_muldiv_if #(.WIDTH(32)) bus32 ();
  mips_muldiv_if #(.WIDTH(8))  bus8  ();

  mips_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  mips_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on the 32-bit unit and observe 45 following edges.
  // poke_at/cancel_at: edge index after which a stray start / cancel is driven (-1 = never, cancel 0 = with start).
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int poke_at, input logic [2:0] poke_op, input int cancel_at,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                       output int n, output int busy_cnt, output int done_cnt);
    bus32.op     = op;
    bus32.a      = a;
    bus32.b      = b;
    bus32.start  = 1'b1;
    bus32.cancel = (cancel_at == 0);
    @(posedge clk); #1;
    bus32.start  = 1'b0;
    bus32.cancel = 1'b0;
    busy_cnt = bus32.busy ? 1 : 0;
    done_cnt = bus32.done ? 1 : 0;
    n = -1;
    dz = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      if (poke_at == i - 1) begin
        bus32.start = 1'b1;
        bus32.op    = poke_op;
        bus32.a     = 32'h99;
      end
      if (cancel_at == i - 1 && i > 1) bus32.cancel = 1'b1;
      @(posedge clk); #1;
      bus32.start  = 1'b0;
      bus32.cancel = 1'b0;
      if (bus32.busy) busy_cnt++;
      if (bus32.done) begin
        if (n < 0) begin
          n  = i;
          dz = bus32.dz;
        end
        done_cnt++;
      end
    end
    hi = bus32.hi;
    lo = bus32.lo;
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] hi, output logic [7:0] lo, output int n, output int busy_cnt);
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    busy_cnt = bus8.busy ? 1 : 0;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus8.busy) busy_cnt++;
      if (bus8.done && n < 0) n = i;
    end
    hi = bus8.hi;
    lo = bus8.lo;
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus32.busy, bus32.done, bus32.dz} !== 3'b000 || bus32.hi !== 32'h0 || bus32.lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset32: busy/done/dz=%b hi=%h lo=%h, want 000/0/0",
               {bus32.busy, bus32.done, bus32.dz}, bus32.hi, bus32.lo);
    end
    vectors++;
    if ({bus8.busy, bus8.done, bus8.dz} !== 3'b000 || bus8.hi !== 8'h0 || bus8.lo !== 8'h0) begin
      miscompares++;
      $display("FAIL reset8: busy/done/dz=%b hi=%h lo=%h, want 000/0/0",
               {bus8.busy, bus8.done, bus8.dz}, bus8.hi, bus8.lo);
    end
  endtask

  task automatic test_multu();
    logic [31:0] h, l; logic z; int n, bc, dc;
    run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, OP_MULT, -1, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL multu_max: hi=%h lo=%h, want fffffffe/00000001", h, l);
    end
    vectors++;
    if (n !== 33 || bc !== 33 || dc !== 1) begin
      miscompares++;
      $display("FAIL multu_timing: done_edge=%0d busy_cycles=%0d done_cycles=%0d, want 33/33/1", n, bc, dc);
    end
  endtask

  task automatic test_signed();
    logic [31:0] h, l; logic z; int n, bc, dc;
    run32(OP_MULT, 32'hFFFF_FFFD, 32'd5, -1, OP_MULT, -1, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFF1 || n !== 33) begin
      miscompares++;
      $display("FAIL mult_neg: hi=%h lo=%h edge=%0d, want ffffffff/fffffff1/33", h, l, n);
    end
    run32(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, OP_MULT, -1, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD || z !== 1'b0) begin
      miscompares++;
      $display("FAIL div_neg: hi=%h lo=%h dz=%b, want ffffffff/fffffffd/0", h, l, z);
    end
    run32(OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, OP_MULT, -1, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'h0000_0001 || l !== 32'hFFFF_FFFD) begin
      miscompares++;
      $display("FAIL div_negdivisor: hi=%h lo=%h, want 00000001/fffffffd", h, l);
    end
  endtask

  task automatic test_div_special();
    logic [31:0] h, l; logic z; int n, bc, dc;
    run32(OP_DIVU, 32'd5, 32'd0, -1, OP_MULT, -1, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'd5 || l !== 32'hFFFF_FFFF || z !== 1'b1 || n !== 33) begin
      miscompares++;
      $display("FAIL divu_zero: hi=%h lo=%h dz=%b edge=%0d, want 00000005/ffffffff/1/33", h, l, z, n);
    end
    run32(OP_DIV, 32'hFFFF_FFF9, 32'd0, -1, OP_MULT, -1, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'hFFFF_FFF9 || l !== 32'hFFFF_FFFF || z !== 1'b1) begin
      miscompares++;
      $display("FAIL div_zero_signed: hi=%h lo=%h dz=%b, want fffffff9/ffffffff/1", h, l, z);
    end
    vectors++;
    if (bus32.dz !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_idle: dz=%b, want 0", bus32.dz);
    end
    run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, OP_MULT, -1, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'h0 || l !== 32'h8000_0000 || z !== 1'b0) begin
      miscompares++;
      $display("FAIL div_overflow: hi=%h lo=%h dz=%b, want 00000000/80000000/0", h, l, z);
    end
  endtask

  task automatic test_mthi_mtlo();
    bus32.op = OP_MTHI; bus32.a = 32'h1234; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    vectors++;
    if (bus32.hi !== 32'h1234 || bus32.done !== 1'b1 || bus32.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi: hi=%h done=%b busy=%b, want 00001234/1/0", bus32.hi, bus32.done, bus32.busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi_pulse: done=%b busy=%b, want 0/0", bus32.done, bus32.busy);
    end
    bus32.op = OP_MTLO; bus32.a = 32'hABCD; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    vectors++;
    if (bus32.lo !== 32'hABCD || bus32.hi !== 32'h1234 || bus32.done !== 1'b1) begin
      miscompares++;
      $display("FAIL mtlo: lo=%h hi=%h done=%b, want 0000abcd/00001234/1", bus32.lo, bus32.hi, bus32.done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved();
    logic [31:0] h, l; logic z; int n, bc, dc;
    run32(3'b110, 32'h5555, 32'h7, -1, OP_MULT, -1, h, l, z, n, bc, dc);
    vectors++;
    if (dc !== 0 || bc !== 0 || h !== 32'h1234 || l !== 32'hABCD) begin
      miscompares++;
      $display("FAIL reserved_op: done_cycles=%0d busy_cycles=%0d hi=%h lo=%h, want 0/0/00001234/0000abcd",
               dc, bc, h, l);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] h, l; logic z; int n, bc, dc;
    bus32.op = OP_MTHI; bus32.a = 32'h11; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.op = OP_MTLO; bus32.a = 32'h22;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    @(posedge clk); #1;
    run32(OP_DIVU, 32'd100, 32'd7, 5, OP_MULT, 10, h, l, z, n, bc, dc);
    vectors++;
    if (dc !== 0 || bc !== 11 || h !== 32'h11 || l !== 32'h22) begin
      miscompares++;
      $display("FAIL cancel_calc: done_cycles=%0d busy_cycles=%0d hi=%h lo=%h, want 0/11/00000011/00000022",
               dc, bc, h, l);
    end
    run32(OP_DIVU, 32'd100, 32'd7, -1, OP_MULT, -1, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'd2 || l !== 32'd14 || n !== 33 || dc !== 1) begin
      miscompares++;
      $display("FAIL divu_rerun: hi=%h lo=%h edge=%0d done_cycles=%0d, want 2/14/33/1", h, l, n, dc);
    end
    run32(OP_MULTU, 32'd3, 32'd4, -1, OP_MULT, 32, h, l, z, n, bc, dc);
    vectors++;
    if (dc !== 0 || bc !== 33 || h !== 32'd2 || l !== 32'd14) begin
      miscompares++;
      $display("FAIL cancel_fixup: done_cycles=%0d busy_cycles=%0d hi=%h lo=%h, want 0/33/2/14", dc, bc, h, l);
    end
    run32(OP_MULTU, 32'd6, 32'd7, -1, OP_MULT, 0, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'd0 || l !== 32'd42 || n !== 33) begin
      miscompares++;
      $display("FAIL start_with_cancel: hi=%h lo=%h edge=%0d, want 0/42/33", h, l, n);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l; logic z; int n, bc, dc;
    run32(OP_DIVU, 32'd100, 32'd7, 5, OP_MTHI, -1, h, l, z, n, bc, dc);
    vectors++;
    if (h !== 32'd2 || l !== 32'd14 || n !== 33 || dc !== 1 || bc !== 33) begin
      miscompares++;
      $display("FAIL start_while_busy: hi=%h lo=%h edge=%0d done_cycles=%0d busy=%0d, want 2/14/33/1/33",
               h, l, n, dc, bc);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] h8, l8; int n, bc;
    bus32.op = OP_MULTU; bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h3; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    vectors++;
    if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.hi !== 32'h0 || bus32.lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async: busy=%b done=%b hi=%h lo=%h, want 0/0/0/0",
               bus32.busy, bus32.done, bus32.hi, bus32.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL reset_resume: busy=%b done=%b, want 0/0", bus32.busy, bus32.done);
      end
    end
    run8(OP_MULTU, 8'hFF, 8'hFF, h8, l8, n, bc);
    vectors++;
    if (h8 !== 8'hFE || l8 !== 8'h01 || n !== 9 || bc !== 9) begin
      miscompares++;
      $display("FAIL multu_w8: hi=%h lo=%h edge=%0d busy=%0d, want fe/01/9/9", h8, l8, n, bc);
    end
    run8(OP_DIV, 8'h80, 8'hFF, h8, l8, n, bc);
    vectors++;
    if (h8 !== 8'h00 || l8 !== 8'h80 || n !== 9) begin
      miscompares++;
      $display("FAIL div_overflow_w8: hi=%h lo=%h edge=%0d, want 00/80/9", h8, l8, n);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    bus32.start  = 1'b0; bus32.op = 3'b000; bus32.a = '0; bus32.b = '0; bus32.cancel = 1'b0;
    bus8.start   = 1'b0; bus8.op  = 3'b000; bus8.a  = '0; bus8.b  = '0; bus8.cancel  = 1'b0;
    #12;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    test_multu();
    test_signed();
    test_div_special();
    test_mthi_mtlo();
    test_reserved();
    test_cancel();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
Iterative multiply/divide unit with HI/LO result registers. It extends the processor's single-cycle ALU with MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU in the datapath, driven by the controller through a start/busy/done handshake. The datapath width is parametrised, and an in-flight operation can be cancelled.

Parameters:
WIDTH, 32, operand and HI/LO width; legal range 4..64.
CW, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
b  in  WIDTH  rt operand (divisor / multiplier)
cancel  in  1  synchronous abort of a CALC/FIXUP operation
busy  out  1  operation in progress
done  out  1  one-cycle pulse: HI/LO just updated
dz  out  1  divide-by-zero flag; valid with done, else 0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, dz=0, hi=0, lo=0, counter=0.
- States: IDLE, CALC, FIXUP.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU:
  - Latch the operand magnitudes (absolute values for signed ops) and the result signs.
  - counter=WIDTH; next state CALC; busy=1 from the next cycle.
- IDLE, start=1, op=MTHI/MTLO:
  - Write a to hi or lo at that edge; done=1 for the following cycle.
  - busy stays 0; state stays IDLE.
- IDLE, start=1, op reserved: ignored; no done pulse.
- CALC, one step per cycle, counter decrements:
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - When counter reaches 1, next state is FIXUP.
- FIXUP, single cycle:
  - Apply signs: a negative product is two's-complemented over 2*WIDTH bits.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Write hi/lo at the exit edge; next state IDLE; busy=0; done=1 for one cycle.
- Latency: start edge to the done-asserted cycle is WIDTH+1 edges. busy is high for exactly WIDTH+1 cycles.
- Multiply result: {hi,lo} = full 2*WIDTH product.
- Divide result: lo = quotient, hi = remainder.
- Divide by zero (b=0, DIV or DIVU):
  - Full latency still applies.
  - lo = all ones, hi = a unchanged (signed ops included); dz=1 together with done.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = -2^(WIDTH-1), hi = 0, dz=0.
- start while busy: ignored, not queued; the operation in flight is unaffected.
- cancel=1 in CALC or FIXUP: next state IDLE; hi/lo keep their prior values; no done pulse.
- cancel in IDLE: no effect.
- cancel and the FIXUP exit edge together: cancel wins; hi/lo are not written.
- start and cancel together in IDLE: start is accepted.
- reset mid-operation: immediate return to the reset values above; no done pulse.
- hi and lo are always registered outputs; they are never combinational from a or b.

Decomposition:
- Package mips_muldiv_pkg holds:
  - op encodings (OP_MULT..OP_MTLO) as localparams;
  - the state enum (IDLE/CALC/FIXUP);
  - helper function neg(x) for two's complement.
- One sub-module is natural: mips_muldiv_step, purely combinational. It computes one shift-add or shift-subtract iteration from {acc, operand, mode}. The top level owns the FSM, counter, sign latches and HI/LO.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges: done=1, hi=0xFFFFFFFE, lo=0x00000001, busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, dz=1 with done. Also DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
- With hi=0x11, lo=0x22 preloaded, start DIVU 100/7:
  - pulse start (MULT) at cycle 5 -> ignored;
  - pulse cancel at cycle 10 -> busy=0 next cycle, hi=0x11, lo=0x22, no done.
  - Rerun DIVU 100/7 without interference -> lo=14, hi=2.
- MTHI a=0x1234 -> hi=0x1234 after one edge, done one cycle, busy never 1. MTLO a=0xABCD -> lo=0xABCD, hi unchanged.
- Drop reset to 0 mid-CALC -> busy, done, hi and lo go to 0 without waiting for clk. After release, run WIDTH=8 (separate elaboration): MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 edges.
